// File: rtl/register_serializer.sv
// Parallel-to-serial readout stage: takes one word over a load handshake and
// shifts it out one bit per serial handshake, pulsing done after the last bit.
module register_serializer #(
  parameter int BUS_WIDTH = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BUS_WIDTH-1:0] load_data,
  input  logic                 load_valid,
  output logic                 load_ready,
  output logic                 ser_out,
  output logic                 ser_valid,
  input  logic                 ser_ready,
  output logic                 done
);

  localparam int CNT_W = $clog2(BUS_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUS_WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [BUS_WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic                 ser_out_q, ser_out_d;
  logic                 ser_valid_q, ser_valid_d;
  logic                 load_ready_q, load_ready_d;

  // Bit presented at the output end of a word.
  function automatic logic out_bit(input logic [BUS_WIDTH-1:0] w);
    if (MSB_FIRST) begin
      return w[BUS_WIDTH-1];
    end else begin
      return w[0];
    end
  endfunction

  // Move the word one place toward the output end, zero filling behind it.
  function automatic logic [BUS_WIDTH-1:0] shift_word(input logic [BUS_WIDTH-1:0] w);
    if (MSB_FIRST) begin
      return {w[BUS_WIDTH-2:0], 1'b0};
    end else begin
      return {1'b0, w[BUS_WIDTH-1:1]};
    end
  endfunction

  // Next-state and next-output computation for the load/shift sequence.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    done_d       = 1'b0;
    ser_out_d    = ser_out_q;
    ser_valid_d  = ser_valid_q;
    load_ready_d = load_ready_q;
    case (state_q)
      IDLE: begin
        if (load_valid && load_ready_q) begin
          state_d      = SHIFT;
          shreg_d      = load_data;
          cnt_d        = {CNT_W{1'b0}};
          ser_out_d    = out_bit(load_data);
          ser_valid_d  = 1'b1;
          load_ready_d = 1'b0;
        end else begin
          ser_out_d    = 1'b0;
          ser_valid_d  = 1'b0;
          load_ready_d = 1'b1;
        end
      end
      SHIFT: begin
        // Outputs only move on an accepted transfer, so a stall holds ser_out.
        if (ser_valid_q && ser_ready) begin
          shreg_d = shift_word(shreg_q);
          if (cnt_q == CNT_LAST) begin
            state_d      = IDLE;
            cnt_d        = {CNT_W{1'b0}};
            done_d       = 1'b1;
            ser_out_d    = 1'b0;
            ser_valid_d  = 1'b0;
            load_ready_d = 1'b1;
          end else begin
            cnt_d     = cnt_q + CNT_W'(1);
            ser_out_d = out_bit(shift_word(shreg_q));
          end
        end else begin
          shreg_d = shreg_q;
          cnt_d   = cnt_q;
        end
      end
      default: begin
        state_d      = IDLE;
        shreg_d      = {BUS_WIDTH{1'b0}};
        cnt_d        = {CNT_W{1'b0}};
        ser_out_d    = 1'b0;
        ser_valid_d  = 1'b0;
        load_ready_d = 1'b1;
      end
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      shreg_q      <= {BUS_WIDTH{1'b0}};
      cnt_q        <= {CNT_W{1'b0}};
      done_q       <= 1'b0;
      ser_out_q    <= 1'b0;
      ser_valid_q  <= 1'b0;
      load_ready_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      done_q       <= done_d;
      ser_out_q    <= ser_out_d;
      ser_valid_q  <= ser_valid_d;
      load_ready_q <= load_ready_d;
    end
  end

  assign load_ready = load_ready_q;
  assign ser_out    = ser_out_q;
  assign ser_valid  = ser_valid_q;
  assign done       = done_q;

endmodule

// File: tb/tb_register_serializer.sv
// Directed bench: an 8-bit MSB-first instance and a 4-bit LSB-first instance.
module tb_register_serializer;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic [7:0] ld8 = 8'h00;
  logic       lv8 = 1'b0, sr8 = 1'b0;
  logic       lr8, so8, sv8, d8;
  logic [3:0] ld4 = 4'h0;
  logic       lv4 = 1'b0, sr4 = 1'b0;
  logic       lr4, so4, sv4, d4;

  int checks = 0;
  int errors = 0;

  register_serializer #(.BUS_WIDTH(8), .MSB_FIRST(1'b1)) dut8 (
    .clk(clk), .rst_n(rst_n), .load_data(ld8), .load_valid(lv8), .load_ready(lr8),
    .ser_out(so8), .ser_valid(sv8), .ser_ready(sr8), .done(d8)
  );

  register_serializer #(.BUS_WIDTH(4), .MSB_FIRST(1'b0)) dut4 (
    .clk(clk), .rst_n(rst_n), .load_data(ld4), .load_valid(lv4), .load_ready(lr4),
    .ser_out(so4), .ser_valid(sv4), .ser_ready(sr4), .done(d4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load8(input logic [7:0] w);
    chk("load_ready_before_load", {63'd0, lr8}, 64'd1);
    lv8 = 1'b1;
    ld8 = w;
    step();
    lv8 = 1'b0;
    ld8 = 8'h00;
  endtask

  // Drain one word from dut8 with a repeating ser_ready pattern; optionally
  // pulse load_valid mid-word to prove it is ignored.
  task automatic drain8(input logic [7:0] w, input logic [3:0] rpat, input bit intrude);
    int   nb = 0;
    logic last = 1'b0;
    bit   stalled = 1'b0;
    for (int c = 0; c < 64 && nb < 8; c++) begin
      chk("ser_valid_high", {63'd0, sv8}, 64'd1);
      chk("load_ready_low", {63'd0, lr8}, 64'd0);
      chk("done_low", {63'd0, d8}, 64'd0);
      if (stalled) chk("hold_on_stall", {63'd0, so8}, {63'd0, last});
      sr8 = rpat[c % 4];
      lv8 = intrude && (c == 2);
      ld8 = 8'h00;
      if (sr8) begin
        chk("bit", {63'd0, so8}, {63'd0, w[7 - nb]});
        nb++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        last = so8;
      end
      step();
    end
    lv8 = 1'b0;
    chk("bit_count", 64'(nb), 64'd8);
    chk("done_high", {63'd0, d8}, 64'd1);
    chk("ser_valid_low_after", {63'd0, sv8}, 64'd0);
    chk("load_ready_high_after", {63'd0, lr8}, 64'd1);
    step();
    chk("done_single_pulse", {63'd0, d8}, 64'd0);
  endtask

  initial begin
    logic [7:0] w1, w2;
    logic [3:0] w4;
    logic       ev, eo, ed;

    // Asynchronous reset asserted mid-cycle
    #3 rst_n = 1'b0;
    #1;
    chk("rst_load_ready", {63'd0, lr8}, 64'd1);
    chk("rst_ser_valid", {63'd0, sv8}, 64'd0);
    chk("rst_ser_out", {63'd0, so8}, 64'd0);
    chk("rst_done", {63'd0, d8}, 64'd0);
    chk("rst4_load_ready", {63'd0, lr4}, 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Basic MSB-first, continuous ready
    sr8 = 1'b1;
    load8(8'hA5);
    drain8(8'hA5, 4'b1111, 1'b0);

    // Backpressure with ready pattern 1,0,0,1
    load8(8'h3C);
    drain8(8'h3C, 4'b1001, 1'b0);

    // Load attempt during SHIFT is ignored
    sr8 = 1'b1;
    load8(8'hFF);
    drain8(8'hFF, 4'b1111, 1'b1);
    chk("no_extra_load", {63'd0, sv8}, 64'd0);

    // Back-to-back with held load_valid
    w1 = 8'h81;
    w2 = 8'h7E;
    sr8 = 1'b1;
    lv8 = 1'b1;
    ld8 = w1;
    step();
    ld8 = w2;
    for (int cyc = 1; cyc <= 18; cyc++) begin
      if (cyc <= 8) begin
        ev = 1'b1; eo = w1[8 - cyc]; ed = 1'b0;
      end else if (cyc == 9) begin
        ev = 1'b0; eo = 1'b0; ed = 1'b1;
      end else if (cyc <= 17) begin
        ev = 1'b1; eo = w2[17 - cyc]; ed = 1'b0;
      end else begin
        ev = 1'b0; eo = 1'b0; ed = 1'b1;
      end
      chk("b2b_valid", {63'd0, sv8}, {63'd0, ev});
      chk("b2b_out", {63'd0, so8}, {63'd0, eo});
      chk("b2b_done", {63'd0, d8}, {63'd0, ed});
      if (cyc >= 10) lv8 = 1'b0;
      step();
    end
    chk("b2b_done_after", {63'd0, d8}, 64'd0);

    // Reset mid-word after three bits
    load8(8'hF0);
    sr8 = 1'b1;
    repeat (3) step();
    chk("midword_valid", {63'd0, sv8}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_load_ready", {63'd0, lr8}, 64'd1);
    chk("midrst_ser_valid", {63'd0, sv8}, 64'd0);
    chk("midrst_ser_out", {63'd0, so8}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("postrst_done", {63'd0, d8}, 64'd0);
      chk("postrst_idle", {63'd0, lr8}, 64'd1);
      chk("postrst_valid", {63'd0, sv8}, 64'd0);
    end

    // LSB-first, 4-bit instance
    w4 = 4'b0011;
    chk("w4_load_ready", {63'd0, lr4}, 64'd1);
    lv4 = 1'b1;
    ld4 = w4;
    sr4 = 1'b1;
    step();
    lv4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("w4_valid", {63'd0, sv4}, 64'd1);
      chk("w4_bit", {63'd0, so4}, {63'd0, w4[i]});
      chk("w4_done_low", {63'd0, d4}, 64'd0);
      step();
    end
    chk("w4_done_high", {63'd0, d4}, 64'd1);
    chk("w4_ready_high", {63'd0, lr4}, 64'd1);
    step();
    chk("w4_done_pulse", {63'd0, d4}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_serializer.md
Name: register_serializer

Overview:
- Readout end of the team's enabled-register storage path.
- Accepts a parallel word from a register bank through a valid/ready load handshake.
- Shifts the word out one bit per accepted serial transfer, over a valid/ready serial handshake.
- Sits between the register banks and the serial debug/readout link. Pulses `done` when the last bit of a word has been accepted.

Parameters:
- BUS_WIDTH, 8: width of the parallel word. Legal range 2..64.
- MSB_FIRST, 1: 1 = bit BUS_WIDTH-1 is sent first; 0 = bit 0 is sent first.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- load_data  input  BUS_WIDTH  parallel word to serialize.
- load_valid  input  1  load_data is valid this cycle.
- load_ready  output  1  block can accept a word this cycle.
- ser_out  output  1  current serial bit.
- ser_valid  output  1  ser_out holds a valid bit.
- ser_ready  input  1  downstream accepts ser_out this cycle.
- done  output  1  one-cycle pulse after the final bit of a word is accepted.

Behaviour:
- Reset is asynchronous (rst_n low). It forces:
  - state=IDLE, shift register=0, bit counter=0.
  - done=0, ser_valid=0, ser_out=0, load_ready=1.
- States: IDLE, SHIFT.
- load_ready = (state==IDLE).
- ser_valid = (state==SHIFT).
- ser_out:
  - In SHIFT: shreg[BUS_WIDTH-1] if MSB_FIRST, else shreg[0].
  - In IDLE: 0.
- IDLE:
  - If load_valid && load_ready, capture load_data into shreg, clear the counter, and go to SHIFT next cycle.
  - Otherwise hold all state.
- SHIFT:
  - A bit transfers on a cycle where ser_valid && ser_ready.
  - On a transfer, shreg shifts toward the output end (zero fill) and the counter increments.
  - With no transfer (ser_ready=0), shreg, counter and ser_out hold stable; no bit is skipped or repeated.
  - When the transfer with counter==BUS_WIDTH-1 occurs: next cycle state=IDLE, done=1, counter=0.
- done:
  - Registered, high for exactly one cycle (the first IDLE cycle after the word).
  - That same cycle load_ready=1, so a new word can be loaded. A load in that cycle is legal and is not blocked by done.
- Throughput: BUS_WIDTH cycles per word under continuous ser_ready, plus one IDLE cycle. Minimum word period = BUS_WIDTH+1 cycles.
- Latency: first bit is valid on ser_out one cycle after the load handshake.
- load_valid while in SHIFT is ignored. load_ready=0 there, so the upstream must hold the word. The in-flight word is never corrupted.
- Counter width = clog2(BUS_WIDTH). There is no wrap beyond BUS_WIDTH-1; the terminal transfer always returns to IDLE.
- Reset asserted mid-word aborts immediately:
  - No done pulse.
  - After release, the block is in IDLE with load_ready=1, and the partial word is discarded.
- Held load_valid with continuous ser_ready streams successive words:
  - Each word is loaded on its first IDLE cycle.
  - Exactly one idle bubble appears between words (ser_valid low for one cycle).

Test Plan:
- Reset: drive rst_n low asynchronously mid-cycle, then check that outputs go immediately to load_ready=1, ser_valid=0, ser_out=0, done=0.
- Basic MSB-first (BUS_WIDTH=8): load 8'hA5, ser_ready held 1.
  - ser_out = 1,0,1,0,0,1,0,1 on cycles 1..8 after the load.
  - done=1 on cycle 9 only.
  - load_ready=0 on cycles 1..8.
- Backpressure: load 8'h3C and toggle ser_ready 1,0,0,1,... Each accepted bit matches 0,0,1,1,1,1,0,0 in order, and ser_out holds stable while ser_ready=0.
- Load during SHIFT: while shifting 8'hFF, pulse load_valid with 8'h00. The pulse is ignored, all 8 bits out are 1, then done.
- Back-to-back: hold load_valid with 8'h81 then 8'h7E.
  - Serial stream is 1,0,0,0,0,0,0,1, one bubble, then 0,1,1,1,1,1,1,0.
  - Two done pulses, 9 cycles apart.
- Reset mid-word plus parameter check:
  - Assert rst_n low after 3 bits of 8'hF0. Expect no done, and idle state after release.
  - Separately, MSB_FIRST=0, BUS_WIDTH=4, load 4'b0011. Expect ser_out = 1,1,0,0, then done.
